// File: rtl/mod_exp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mod_exp_ctrl_pkg
// Brief   : Shared constants and types for the modular-exponent sequencer.
// Revision: 1.0  initial release
// ============================================================================
package mod_exp_ctrl_pkg;

    localparam int ABITS_DEF      = 8;
    localparam int DBITS_DEF      = 256;
    localparam int BITLEN_DEF     = 256;
    localparam int LOG_BITLEN_DEF = 8;

    localparam logic [1:0] OPXX = 2'd0;
    localparam logic [1:0] OPXM = 2'd1;
    localparam logic [1:0] OPX1 = 2'd2;

    localparam int ADDR_X = 0;
    localparam int ADDR_M = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT_X = 3'd1,
        S_INIT_M = 3'd2,
        S_SEL    = 3'd3,
        S_ISSUE  = 3'd4,
        S_ARM    = 3'd5,
        S_WAIT   = 3'd6,
        S_NEXT   = 3'd7
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mod_exp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : mod_exp_ctrl_if
// Brief   : Job handshake to mon_prod plus the operand-RAM init write port.
// Revision: 1.0  initial release
// ============================================================================
interface mod_exp_ctrl_if #(
    parameter int ABITS      = 8,
    parameter int DBITS      = 256,
    parameter int BITLEN     = 256,
    parameter int LOG_BITLEN = 8
) ();
    logic                  mp_start;
    logic [1:0]            mp_op_code;
    logic [LOG_BITLEN:0]   mp_count;
    logic                  mp_stop;
    logic [BITLEN:0]       mp_P;
    logic                  init_wr_en;
    logic [ABITS-1:0]      init_wr_addr;
    logic [DBITS-1:0]      init_wr_data;

    modport master (
        output mp_start, mp_op_code, mp_count,
        output init_wr_en, init_wr_addr, init_wr_data,
        input  mp_stop, mp_P
    );

    modport slave (
        input  mp_start, mp_op_code, mp_count,
        input  init_wr_en, init_wr_addr, init_wr_data,
        output mp_stop, mp_P
    );
endinterface
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mod_exp_ctrl
// Brief   : Left-to-right square-and-multiply sequencer driving mon_prod.
// Revision: 1.0  initial release
// ============================================================================
module mod_exp_ctrl
    import mod_exp_ctrl_pkg::*;
#(
    parameter int ABITS      = ABITS_DEF,
    parameter int DBITS      = DBITS_DEF,
    parameter int BITLEN     = BITLEN_DEF,
    parameter int LOG_BITLEN = LOG_BITLEN_DEF,
    parameter int MP_COUNT   = 256,
    parameter int HOLDOFF    = 264
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go_i,
    input  logic [BITLEN-1:0]     exponent_i,
    input  logic [LOG_BITLEN:0]   exp_len_i,
    input  logic [DBITS-1:0]      r_mod_i,
    input  logic [DBITS-1:0]      m_bar_i,
    mod_exp_ctrl_if.master        mp,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [BITLEN-1:0]     result_o
);

    localparam int                  c_HOLD_W   = $clog2(HOLDOFF + 1);
    localparam logic [LOG_BITLEN:0] c_BITLEN_L = (LOG_BITLEN + 1)'(BITLEN);

    state_e                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [LOG_BITLEN:0]    rem_q, rem_d;
    logic [LOG_BITLEN-1:0]  idx_q, idx_d;
    logic [BITLEN-1:0]      exp_q, exp_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [BITLEN-1:0]      result_q, result_d;
    logic                   start_q, start_d;
    logic                   wr_en_q, wr_en_d;
    logic [ABITS-1:0]       wr_addr_q, wr_addr_d;
    logic [DBITS-1:0]       wr_data_q, wr_data_d;
    logic [c_HOLD_W-1:0]    holdoff_q;
    logic [LOG_BITLEN:0]    w_len;

    assign w_len = (exp_len_i > c_BITLEN_L) ? c_BITLEN_L : exp_len_i;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        exp_d     = exp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        start_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (go_i && (holdoff_q == '0)) begin
                    exp_d     = exponent_i;
                    rem_d     = w_len;
                    idx_d     = w_len[LOG_BITLEN-1:0] - 1'b1;
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ABITS'(ADDR_X);
                    wr_data_d = r_mod_i;
                    state_d   = S_INIT_X;
                end
            end
            S_INIT_X: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ABITS'(ADDR_M);
                wr_data_d = m_bar_i;
                state_d   = S_INIT_M;
            end
            S_INIT_M: state_d = S_SEL;
            S_SEL: begin
                op_d    = (rem_q == '0) ? OPX1 : OPXX;
                start_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_ARM;
            // mon_prod's stop is still stale from the previous job here
            S_ARM:   state_d = S_WAIT;
            S_WAIT: begin
                if (mp.mp_stop) begin
                    if (op_q == OPXX) begin
                        if (exp_q[idx_q]) begin
                            op_d    = OPXM;
                            start_d = 1'b1;
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end else if (op_q == OPXM) begin
                        state_d = S_NEXT;
                    end else begin
                        result_d = mp.mp_P[BITLEN-1:0];
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_NEXT: begin
                rem_d   = rem_q - 1'b1;
                idx_d   = idx_q - 1'b1;
                state_d = S_SEL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OPXX;
            rem_q     <= '0;
            idx_q     <= '0;
            exp_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            start_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            holdoff_q <= c_HOLD_W'(HOLDOFF);
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            exp_q     <= exp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            start_q   <= start_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            if (holdoff_q != '0) begin
                holdoff_q <= holdoff_q - 1'b1;
            end
        end
    end

    assign mp.mp_start     = start_q;
    assign mp.mp_op_code   = op_q;
    assign mp.mp_count     = (LOG_BITLEN + 1)'(MP_COUNT);
    assign mp.init_wr_en   = wr_en_q;
    assign mp.init_wr_addr = wr_addr_q;
    assign mp.init_wr_data = wr_data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign result_o        = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mod_exp_ctrl
// Brief   : Self-checking bench with a behavioural mon_prod and modexp model.
// Revision: 1.0  initial release
// ============================================================================
module tb_mod_exp_ctrl;
    import mod_exp_ctrl_pkg::*;

    localparam int ABITS = 8, DBITS = 256, BITLEN = 256, LOG_BITLEN = 8;
    localparam int HOLDOFF = 264;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                go = 1'b0;
    logic [BITLEN-1:0]   exponent = '0;
    logic [LOG_BITLEN:0] exp_len = '0;
    logic [DBITS-1:0]    r_mod = '0;
    logic [DBITS-1:0]    m_bar = '0;
    logic                busy, done;
    logic [BITLEN-1:0]   result;

    mod_exp_ctrl_if #(.ABITS(ABITS), .DBITS(DBITS), .BITLEN(BITLEN), .LOG_BITLEN(LOG_BITLEN)) bus ();

    mod_exp_ctrl #(
        .ABITS(ABITS), .DBITS(DBITS), .BITLEN(BITLEN), .LOG_BITLEN(LOG_BITLEN),
        .MP_COUNT(256), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .rst(rst), .go_i(go), .exponent_i(exponent), .exp_len_i(exp_len),
        .r_mod_i(r_mod), .m_bar_i(m_bar), .mp(bus.master),
        .busy_o(busy), .done_o(done), .result_o(result)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural mon_prod over small moduli: P = A*B*R^-1 mod m
    longint m_mod = 13, rinv = 1;
    longint ram [0:3] = '{0, 0, 0, 0};
    logic         stub_stop = 1'b1;
    logic [256:0] stub_P = '0;
    logic         stub_run = 1'b0, stub_first = 1'b0;
    logic [3:0]   stub_cnt = '0;
    logic [1:0]   stub_op = '0;

    assign bus.mp_stop = stub_stop;
    assign bus.mp_P    = stub_P;

    function automatic longint mont(input longint a, input longint b);
        return ((a * b) % m_mod) * rinv % m_mod;
    endfunction

    always @(posedge clk) begin
        longint res;
        if (bus.init_wr_en) ram[bus.init_wr_addr[1:0]] <= longint'(bus.init_wr_data[63:0]);
        if (bus.mp_start) begin
            stub_run   <= 1'b1;
            stub_first <= 1'b1;
            stub_op    <= bus.mp_op_code;
            stub_cnt   <= 4'($urandom_range(2, 6));
        end else if (stub_run) begin
            stub_first <= 1'b0;
            if (stub_first) stub_stop <= 1'b0;
            if (stub_cnt == 4'd1) begin
                case (stub_op)
                    2'd0:    res = mont(ram[0], ram[0]);
                    2'd1:    res = mont(ram[0], ram[2]);
                    default: res = mont(ram[0], 1);
                endcase
                stub_stop <= 1'b1;
                stub_P    <= 257'(res);
                ram[0]    <= res;
                stub_run  <= 1'b0;
            end
            stub_cnt <= stub_cnt - 4'd1;
        end
    end

    logic [1:0]       op_log[$];
    logic [ABITS-1:0] wa_log[$];
    logic [DBITS-1:0] wd_log[$];
    int start_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (bus.mp_start) begin
            op_log.push_back(bus.mp_op_code);
            start_cnt++;
        end
        if (bus.init_wr_en) begin
            wa_log.push_back(bus.init_wr_addr);
            wd_log.push_back(bus.init_wr_data);
        end
        if (done) done_cnt++;
    end

    task automatic setup(input longint mm, input longint xx, input logic [255:0] e, input int len);
        longint r = 1;
        m_mod = mm;
        for (int k = 0; k < 256; k++) r = (r * 2) % mm;
        rinv = 0;
        for (longint k = 1; k < mm; k++) if (((k * r) % mm) == 1 && rinv == 0) rinv = k;
        r_mod    = DBITS'(r);
        m_bar    = DBITS'((xx * r) % mm);
        exponent = e;
        exp_len  = (LOG_BITLEN + 1)'(len);
    endtask

    task automatic run(input string nm, input longint mm, input longint xx, input logic [255:0] e,
                       input int len, input bit hold_go, input bit mid_pulse);
        logic [1:0] exp_ops[$];
        longint ref_res = 1 % mm, base = xx % mm;
        int lc = (len > BITLEN) ? BITLEN : len;
        int cyc = 0, bad = -1;
        setup(mm, xx, e, len);
        for (int k = 0; k < lc; k++) begin
            if (e[k]) ref_res = (ref_res * base) % mm;
            base = (base * base) % mm;
        end
        for (int k = lc - 1; k >= 0; k--) begin
            exp_ops.push_back(OPXX);
            if (e[k]) exp_ops.push_back(OPXM);
        end
        exp_ops.push_back(OPX1);
        op_log.delete(); wa_log.delete(); wd_log.delete();
        done_cnt = 0;
        go = 1'b1;
        while (!busy && cyc < HOLDOFF + 50) begin @(negedge clk); cyc++; end
        chk_val({nm, "_accept"}, busy, 1'b1);
        if (!hold_go) go = 1'b0;
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (mid_pulse && cyc == 40) go = 1'b1;
            if (mid_pulse && !hold_go && cyc == 42) go = 1'b0;
        end
        go = 1'b0;
        chk_val({nm, "_done_seen"}, done, 1'b1);
        chk_val({nm, "_result"}, result, 256'(ref_res));
        chk_val({nm, "_busy_at_done"}, busy, 1'b0);
        repeat (4) @(negedge clk);
        chk_val({nm, "_busy_after"}, busy, 1'b0);
        chk_val({nm, "_done_pulses"}, done_cnt, 1);
        chk_val({nm, "_result_held"}, result, 256'(ref_res));
        chk_val({nm, "_n_jobs"}, op_log.size(), exp_ops.size());
        for (int k = 0; k < exp_ops.size() && k < op_log.size(); k++)
            if (op_log[k] !== exp_ops[k] && bad < 0) bad = k;
        chk_val({nm, "_op_seq_bad_idx"}, bad, -1);
        chk_val({nm, "_n_writes"}, wa_log.size(), 2);
        if (wa_log.size() == 2) begin
            chk_val({nm, "_wr0_addr"}, wa_log[0], ADDR_X);
            chk_val({nm, "_wr0_data"}, wd_log[0], r_mod);
            chk_val({nm, "_wr1_addr"}, wa_log[1], ADDR_M);
            chk_val({nm, "_wr1_data"}, wd_log[1], m_bar);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk_val({nm, "_mp_start"}, bus.mp_start, 1'b0);
        chk_val({nm, "_op_code"}, bus.mp_op_code, 2'd0);
        chk_val({nm, "_wr_en"}, bus.init_wr_en, 1'b0);
        chk_val({nm, "_wr_addr"}, bus.init_wr_addr, '0);
        chk_val({nm, "_wr_data"}, bus.init_wr_data, '0);
        chk_val({nm, "_busy"}, busy, 1'b0);
        chk_val({nm, "_done"}, done, 1'b0);
        chk_val({nm, "_result"}, result, '0);
        chk_val({nm, "_mp_count"}, bus.mp_count, 9'd256);
    endtask

    initial begin
        int cyc;
        logic [255:0] e_rnd;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");

        // go held from reset release is accepted exactly when holdoff expires
        setup(13, 4, 256'd11, 4);
        rst = 1'b0;
        go  = 1'b1;
        cyc = 0;
        while (!busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) chk_val("holdoff_early_busy", busy, 1'b0);
        end
        chk_val("holdoff_accept_cycle", cyc, HOLDOFF + 1);
        chk_val("holdoff_no_early_start", start_cnt, 0);
        go  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run("e11", 13, 4, 256'd11, 4, 1'b0, 1'b0);
        run("len0", 13, 4, 256'd11, 0, 1'b0, 1'b0);
        run("hold_go", 13, 4, 256'd11, 4, 1'b1, 1'b1);
        run("mid_pulse", 13, 4, 256'hB, 4, 1'b0, 1'b1);

        // abort while waiting on mon_prod
        go = 1'b1;
        cyc = 0;
        while (!busy && cyc < 50) begin @(negedge clk); cyc++; end
        go = 1'b0;
        cyc = 0;
        while (!bus.mp_start && cyc < 50) begin @(negedge clk); cyc++; end
        chk_val("abort_saw_start", bus.mp_start, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort");
        rst = 1'b0;
        run("after_abort", 13, 4, 256'd11, 4, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int w = 0; w < 8; w++) e_rnd[w*32 +: 32] = $urandom;
            run($sformatf("rnd%0d", t), longint'($urandom_range(1, 2047)) * 2 + 1,
                longint'($urandom_range(0, 2)), e_rnd,
                (t == 0) ? 256 : (t == 1) ? 300 : (t == 2) ? 1 : int'($urandom_range(2, 64)),
                1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Sequencer that sits directly upstream of mon_prod and computes x^e mod m by left-to-right square-and-multiply.
- Preloads the Montgomery-domain operands into the shared operand RAM, then issues OPXX / OPXM / OPX1 jobs to mon_prod over its start/stop handshake.
- Captures the final normal-domain result from mon_prod's P.
- Top level ORs this block's init write port with mon_prod's write port into the single RAM write port.

Parameters:
- ABITS, 8, RAM address width.
- DBITS, 256, RAM data width (= operand width).
- BITLEN, 256, modulus/exponent width.
- LOG_BITLEN, 8, log2(BITLEN).
- MP_COUNT, 256, iteration count driven to mon_prod mp_count.
- HOLDOFF, 264, cycles after reset during which go is ignored (≥ MP_COUNT+8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  start request; sampled in IDLE only
- exponent  in  BITLEN  e; must be stable from go until done
- exp_len  in  LOG_BITLEN+1  number of exponent bits processed, MSB index exp_len-1 down to 0
- r_mod  in  DBITS  R mod m (Montgomery 1)
- m_bar  in  DBITS  x·R mod m (Montgomery base)
- mp_start  out  1  one-cycle start pulse to mon_prod
- mp_op_code  out  2  0=OPXX, 1=OPXM, 2=OPX1
- mp_count  out  LOG_BITLEN+1  constant MP_COUNT
- mp_stop  in  1  mon_prod completion flag (level, stale until mon_prod's next start)
- mp_P  in  BITLEN+1  mon_prod result
- init_wr_en  out  1  RAM write enable
- init_wr_addr  out  ABITS  RAM write address
- init_wr_data  out  DBITS  RAM write data
- busy  out  1  high from go acceptance until done
- done  out  1  one-cycle pulse, result valid
- result  out  BITLEN  x^e mod m, held until next done

Behaviour:
- Reset values: mp_start=0, mp_op_code=0, init_wr_en=0, init_wr_addr=0, init_wr_data=0, busy=0, done=0, result=0, state=IDLE, holdoff counter=HOLDOFF.
- rst takes priority over everything, including mid-operation; the controller aborts immediately.
- mon_prod has no reset, so an in-flight job may still write address 0. This is covered by the holdoff counter, which decrements to 0 after reset; go is ignored while the counter is nonzero.
- RAM map (fixed): address 0 holds x_bar (working value, overwritten by every mon_prod result); address 2 holds M_bar.
- IDLE: when go=1 and holdoff=0: latch exponent and exp_len, set busy=1, set bit index i = exp_len-1, go to INIT_X.
- INIT_X: write r_mod to address 0 (init_wr_en=1 this cycle only), then INIT_M.
- INIT_M: write m_bar to address 2, then SEL.
- SEL:
  - if the remaining bit count is 0, go to ISSUE with op=OPX1;
  - else go to ISSUE with op=OPXX.
- ISSUE: mp_start=1 for exactly one cycle with mp_op_code = op, then ARM.
- ARM: one cycle during which mp_stop is ignored, because mon_prod clears stop one cycle after start. Then WAIT.
- WAIT: hold mp_op_code stable; stay until mp_stop=1. Then:
  - after OPXX: if exponent[i]=1, go to ISSUE with OPXM; else go to NEXT.
  - after OPXM: go to NEXT.
  - after OPX1: result <= mp_P[BITLEN-1:0], done=1 for one cycle, busy=0, return to IDLE.
- NEXT: decrement the remaining count and i, then SEL. The index wraps are never used because the remaining count gates the loop.
- exp_len=0: no squares; a single OPX1 job, giving result = 1 mod m.
- exp_len > BITLEN: clamp to BITLEN.
- go while busy: ignored.
- Job count per run = exp_len + popcount(exponent[exp_len-1:0]) + 1.
- Latency per run = 2 (init) + per job (1 SEL/NEXT + 1 ISSUE + 1 ARM + mon_prod time) + 1.

Decomposition:
- Shared package mp_pkg holds:
  - op-code constants OPXX/OPXM/OPX1;
  - RAM address constants ADDR_X=0, ADDR_M=2;
  - the BITLEN/LOG_BITLEN/DBITS/ABITS defaults.
- No sub-module needed. Exponent bit select and the holdoff counter stay inline.

Test Plan:
- Reset, then go during the first 10 cycles -> ignored: busy stays 0, no mp_start until holdoff expires.
- exponent=4'b1011, exp_len=4, stub mon_prod (stop 5 cycles after start) -> mp_op_code sequence XX,XM,XX,XX,XM,XX,XM,X1 (8 pulses), then a single done pulse.
- Full system with real mon_prod: m=13, x=4, e=11 (exp_len=4), r_mod=2^256 mod 13, m_bar=4·2^256 mod 13 -> result=10. Check init writes go to addresses 0 and 2 with the correct data.
- exp_len=0, m=13 -> exactly one OPX1 job, result=1.
- go held high for the whole run, plus a second go pulse mid-run -> no restart; after done, a new run starts only when go is seen in IDLE.
- rst asserted during a WAIT -> next cycle all outputs at reset values; a new go is accepted only after HOLDOFF cycles and produces the correct result (10 for the case above).
